multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the CPU datapath: instruction fetch, register-file decode/read, ALU execute, memory or MMIO access, and register writeback. It drives the register file's regWrite/MemRead/IoRead controls and the PC/IR load strobes. It also handles variable-latency MMIO with a ready handshake and timeout, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/io_wait_timer.sv | 27 ++
 rtl/multicycle_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode/funct3 constants, FSM state encoding and the instruction-class
// decode used by the multi-cycle controller.
package cpu_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [21:0] IO_BASE_HI_DEF = 22'h3FFFFF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_R   = 3'd0,
    K_I   = 3'd1,
    K_LW  = 3'd2,
    K_SW  = 3'd3,
    K_BEQ = 3'd4,
    K_BNE = 3'd5,
    K_BAD = 3'd6
  } kind_t;

  function automatic kind_t decode_kind(input logic [6:0] opcode, input logic [2:0] funct3);
    kind_t k;
    case (opcode)
      OP_R:  k = K_R;
      OP_I:  k = K_I;
      OP_LW: k = K_LW;
      OP_SW: k = K_SW;
      OP_BR: begin
        case (funct3)
          F3_BEQ:  k = K_BEQ;
          F3_BNE:  k = K_BNE;
          default: k = K_BAD;
        endcase
      end
      default: k = K_BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/io_wait_timer.sv
// Up-counter shared by the memory-latency and MMIO-timeout waits; expire flags
// the last cycle of a window of 'limit' cycles.
module io_wait_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [CW-1:0] limit,
  output logic          expire
);

  logic [CW-1:0] cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign expire = (cnt_r == (limit - CW'(1)));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: fetch, decode, execute, memory/MMIO access and
// writeback, with MMIO ready/timeout handling and a retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int          MEM_LAT    = 1,
  parameter logic [21:0] IO_BASE_HI = IO_BASE_HI_DEF,
  parameter int          IO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        io_ready,
  output logic        imem_rd,
  output logic        ir_load,
  output logic        pc_load,
  output logic        pc_src,
  output logic        alu_src,
  output logic        regWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IoRead,
  output logic        IoWrite,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret
);

  localparam int CNT_MAX = (MEM_LAT > IO_TIMEOUT) ? MEM_LAT : IO_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state_r, next_s;
  kind_t         kind_r, kind_s;
  logic          io_sel_r, illegal_r, bus_err_r;
  logic [31:0]   instret_r;
  logic          wait_s, done_s, clear_s, expire_s;
  logic [CW-1:0] limit_s;
  logic          unused_bits_s;

  assign kind_s        = decode_kind(inst[6:0], inst[14:12]);
  assign unused_bits_s = ^{inst[31:15], inst[11:7], alu_result[9:0]};

  io_wait_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_s),
    .limit  (limit_s),
    .expire (expire_s)
  );

  // Counter runs only while a wait is in progress and restarts from 0 once it completes.
  always_comb begin
    wait_s  = 1'b0;
    done_s  = 1'b0;
    limit_s = CW'(MEM_LAT);
    case (state_r)
      S_FETCH: begin
        wait_s = 1'b1;
        done_s = expire_s;
      end
      S_MEM: begin
        if (io_sel_r) begin
          wait_s  = 1'b1;
          limit_s = CW'(IO_TIMEOUT);
          done_s  = io_ready || expire_s;
        end else if (kind_r == K_LW) begin
          wait_s = 1'b1;
          done_s = expire_s;
        end else begin
          wait_s = 1'b0;
          done_s = 1'b0;
        end
      end
      default: begin
        wait_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
    clear_s = !wait_s || done_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  always_comb begin
    next_s = state_r;
    case (state_r)
      S_FETCH:  next_s = expire_s ? S_DECODE : S_FETCH;
      S_DECODE: next_s = (kind_s == K_BAD) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (kind_r)
          K_R, K_I:     next_s = S_WB;
          K_LW, K_SW:   next_s = S_MEM;
          K_BEQ, K_BNE: next_s = S_FETCH;
          default:      next_s = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (io_sel_r) begin
          if (io_ready) begin
            next_s = (kind_r == K_LW) ? S_WB : S_FETCH;
          end else if (expire_s) begin
            next_s = S_TRAP;
          end else begin
            next_s = S_MEM;
          end
        end else if (kind_r == K_LW) begin
          next_s = expire_s ? S_WB : S_MEM;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_WB:    next_s = S_FETCH;
      S_TRAP:  next_s = S_TRAP;
      default: next_s = S_FETCH;
    endcase
  end

  // Latched instruction class, MMIO select, sticky faults and retire count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_r    <= K_R;
      io_sel_r  <= 1'b0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
      instret_r <= 32'd0;
    end else begin
      if (state_r == S_DECODE) begin
        kind_r <= kind_s;
      end
      if (state_r == S_DECODE && kind_s == K_BAD) begin
        illegal_r <= 1'b1;
      end
      if (state_r == S_EXEC) begin
        io_sel_r <= (alu_result[31:10] == IO_BASE_HI);
      end
      if (state_r == S_MEM && io_sel_r && !io_ready && expire_s) begin
        bus_err_r <= 1'b1;
      end
      if (pc_load) begin
        instret_r <= instret_r + 32'd1;
      end
    end
  end

  always_comb begin
    imem_rd  = 1'b0;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    pc_src   = 1'b0;
    alu_src  = 1'b0;
    regWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IoRead   = 1'b0;
    IoWrite  = 1'b0;
    if (!rst) begin
      case (state_r)
        S_FETCH: begin
          imem_rd = 1'b1;
          ir_load = expire_s;
        end
        S_EXEC: begin
          alu_src = (kind_r == K_I) || (kind_r == K_LW) || (kind_r == K_SW);
          if (kind_r == K_BEQ) begin
            pc_load = 1'b1;
            pc_src  = alu_zero;
          end else if (kind_r == K_BNE) begin
            pc_load = 1'b1;
            pc_src  = !alu_zero;
          end else begin
            pc_load = 1'b0;
            pc_src  = 1'b0;
          end
        end
        S_MEM: begin
          if (io_sel_r) begin
            IoRead  = (kind_r == K_LW);
            IoWrite = (kind_r == K_SW);
            pc_load = (kind_r == K_SW) && io_ready;
          end else begin
            MemRead  = (kind_r == K_LW);
            MemWrite = (kind_r == K_SW);
            pc_load  = (kind_r == K_SW);
          end
        end
        // Load data select stays up through writeback.
        S_WB: begin
          regWrite = 1'b1;
          pc_load  = 1'b1;
          MemRead  = (kind_r == K_LW) && !io_sel_r;
          IoRead   = (kind_r == K_LW) && io_sel_r;
        end
        default: begin
          imem_rd = 1'b0;
        end
      endcase
    end else begin
      imem_rd = 1'b0;
    end
  end

  assign illegal = illegal_r;
  assign bus_err = bus_err_r;
  assign instret = instret_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (MEM_LAT=1, IO_TIMEOUT=255).
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, alu_result;
  logic        alu_zero, io_ready;
  logic        imem_rd, ir_load, pc_load, pc_src, alu_src, regWrite;
  logic        MemRead, MemWrite, IoRead, IoWrite, illegal, bus_err;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = 32'd0;
  int n_iowr, n_iord, n_pcl, n_rw;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_LAT(1), .IO_BASE_HI(22'h3FFFFF), .IO_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .inst(inst), .alu_result(alu_result), .alu_zero(alu_zero),
    .io_ready(io_ready), .imem_rd(imem_rd), .ir_load(ir_load), .pc_load(pc_load),
    .pc_src(pc_src), .alu_src(alu_src), .regWrite(regWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IoRead(IoRead), .IoWrite(IoWrite), .illegal(illegal),
    .bus_err(bus_err), .instret(instret)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] alu;
    logic        zero;
    int          io_delay;
    int          cyc;
    int          rw;
    logic        alusrc;
    logic        pcsrc;
    int          memrd;
    int          memwr;
    int          iord;
    int          iowr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge in the first FETCH cycle; leaves at the same phase.
  task automatic run(input vec_t v);
    int cyc = 0, memc = 0, rw = 0, memrd = 0, memwr = 0, iord = 0, iowr = 0, imrd = 0, irl = 0;
    logic as_exec = 1'b0, ps = 1'b0;
    bit done = 1'b0;
    inst = v.inst; alu_result = v.alu; alu_zero = v.zero; io_ready = 1'b0;
    while (!done && cyc < 600) begin
      cyc++;
      if (IoRead || IoWrite) memc++;
      io_ready = (v.io_delay != 0) && (memc == v.io_delay);
      #1;
      rw += int'(regWrite); memrd += int'(MemRead); memwr += int'(MemWrite);
      iord += int'(IoRead); iowr += int'(IoWrite); imrd += int'(imem_rd); irl += int'(ir_load);
      if (cyc == 3) as_exec = alu_src;
      if (pc_load) begin
        done = 1'b1;
        ps = pc_src;
      end
      @(posedge clk); #1;
    end
    io_ready = 1'b0;
    chk({v.name, "_retired"}, 32'(done), 32'd1);
    chk({v.name, "_cycles"}, cyc, v.cyc);
    chk({v.name, "_regwrite"}, rw, v.rw);
    chk({v.name, "_alusrc"}, 32'(as_exec), 32'(v.alusrc));
    chk({v.name, "_pcsrc"}, 32'(ps), 32'(v.pcsrc));
    chk({v.name, "_memrd"}, memrd, v.memrd);
    chk({v.name, "_memwr"}, memwr, v.memwr);
    chk({v.name, "_iord"}, iord, v.iord);
    chk({v.name, "_iowr"}, iowr, v.iowr);
    chk({v.name, "_imem_irload"}, {imrd[15:0], irl[15:0]}, 32'h0001_0001);
    exp_instret = exp_instret + 32'd1;
    #1;
    chk({v.name, "_instret"}, instret, exp_instret);
  endtask

  task automatic observe(input int n);
    n_iowr = 0; n_iord = 0; n_pcl = 0; n_rw = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      n_iowr += int'(IoWrite); n_iord += int'(IoRead);
      n_pcl += int'(pc_load); n_rw += int'(regWrite);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; io_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  initial begin
    vecs[0]  = '{"addi",   32'h00500093, 32'h00000005, 1'b0, 0,   4,   1, 1'b1, 1'b0, 0, 0, 0,   0};
    vecs[1]  = '{"add",    32'h002081b3, 32'h00000007, 1'b0, 0,   4,   1, 1'b0, 1'b0, 0, 0, 0,   0};
    vecs[2]  = '{"beq_t",  32'h00208463, 32'h00000000, 1'b1, 0,   3,   0, 1'b0, 1'b1, 0, 0, 0,   0};
    vecs[3]  = '{"bne_nt", 32'h00209463, 32'h00000000, 1'b1, 0,   3,   0, 1'b0, 1'b0, 0, 0, 0,   0};
    vecs[4]  = '{"bne_t",  32'h00209463, 32'h00000001, 1'b0, 0,   3,   0, 1'b0, 1'b1, 0, 0, 0,   0};
    vecs[5]  = '{"beq_nt", 32'h00208463, 32'h00000001, 1'b0, 0,   3,   0, 1'b0, 1'b0, 0, 0, 0,   0};
    vecs[6]  = '{"sw_ram", 32'h0020a023, 32'h00000100, 1'b0, 0,   4,   0, 1'b1, 1'b0, 0, 1, 0,   0};
    vecs[7]  = '{"lw_ram", 32'h0000a103, 32'h00000100, 1'b0, 0,   5,   1, 1'b1, 1'b0, 2, 0, 0,   0};
    vecs[8]  = '{"lw_io6", 32'h0000a103, 32'hFFFFFC10, 1'b0, 6,   10,  1, 1'b1, 1'b0, 0, 0, 7,   0};
    vecs[9]  = '{"sw_io1", 32'h0020a023, 32'hFFFFFFFC, 1'b0, 1,   4,   0, 1'b1, 1'b0, 0, 0, 0,   1};
    vecs[10] = '{"sw_blw", 32'h0020a023, 32'hFFFFFBFC, 1'b0, 0,   4,   0, 1'b1, 1'b0, 0, 1, 0,   0};
    vecs[11] = '{"lw_edge",32'h0000a103, 32'hFFFFFC00, 1'b0, 255, 259, 1, 1'b1, 1'b0, 0, 0, 256, 0};

    rst = 1'b1; inst = 32'd0; alu_result = 32'd0; alu_zero = 1'b0; io_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {22'd0, imem_rd, ir_load, pc_load, pc_src, alu_src, regWrite,
                        MemRead, MemWrite, IoRead, IoWrite}, 32'd0);
    chk("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run(vecs[i]);

    // Reset in the middle of an MMIO read wait.
    inst = 32'h0000a103; alu_result = 32'hFFFFFC10; io_ready = 1'b0;
    observe(5);
    #1;
    chk("midio_ioread", 32'(IoRead), 32'd1);
    rst = 1'b1;
    #1;
    chk("midio_rst_ioread", 32'(IoRead), 32'd0);
    chk("midio_rst_instret", instret, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midio_refetch", 32'(imem_rd), 32'd1);

    // MMIO store that never completes.
    do_reset();
    inst = 32'h0020a023; alu_result = 32'hFFFFFC00; io_ready = 1'b0;
    observe(300);
    chk("to_iowrite_cycles", n_iowr, 32'd255);
    chk("to_pcload", n_pcl, 32'd0);
    chk("to_bus_err", {30'd0, bus_err, illegal}, 32'd2);
    chk("to_instret", instret, 32'd0);
    chk("to_trap_quiet", {30'd0, imem_rd, IoWrite}, 32'd0);
    rst = 1'b1;
    #1;
    chk("to_rst_bus_err", 32'(bus_err), 32'd0);

    // Unsupported opcode (lui) after one retired instruction.
    do_reset();
    run(vecs[0]);
    inst = 32'h000000b7;
    observe(10);
    chk("lui_illegal", {30'd0, illegal, bus_err}, 32'd2);
    chk("lui_no_retire", n_pcl + n_rw, 32'd0);
    chk("lui_instret", instret, 32'd1);
    rst = 1'b1;
    #1;
    chk("lui_rst", {illegal, instret[30:0]}, 32'd0);

    // Branch opcode with an unsupported funct3.
    do_reset();
    inst = 32'h0020a463;
    observe(6);
    chk("br_f3_illegal", 32'(illegal), 32'd1);
    chk("br_f3_no_pcload", n_pcl, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
